// File: rtl/hb_interp_tx.sv
// 2x half-band interpolator: each 10-bit input yields an FIR-phase and a center-phase 18-bit sample.
// Latency: FIR-phase output valid 1 cycle after accept, center-phase output 2 cycles after accept.
// Backpressure: in_ready drops for the cycle after each accept; there is no output backpressure.
module hb_interp_tx #(
   parameter int C_CENTER = 256,
   parameter int C1       = 144,
   parameter int C3       = -16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [9:0]  in_tx,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [17:0] out_tx,
   output logic        out_valid,
   output logic        out_phase
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FIR  = 2'd1,
      S_CTR  = 2'd2
   } state_t;

   localparam logic signed [21:0] K_CTR = 22'(C_CENTER);
   localparam logic signed [21:0] K_1   = 22'(C1);
   localparam logic signed [21:0] K_3   = 22'(C3);

   state_t             state;
   state_t             state_nxt;
   logic               acc;
   logic               load_fir;
   logic               load_ctr;
   logic               vld_nxt;
   logic [9:0]         d0;
   logic [9:0]         d1;
   logic [9:0]         d2;
   logic [17:0]        hold;
   logic signed [21:0] x_e;
   logic signed [21:0] d0_e;
   logic signed [21:0] d1_e;
   logic signed [21:0] d2_e;
   logic signed [21:0] fir_acc;
   logic signed [21:0] ctr_acc;

   // Clamp a wide signed accumulator into the 18-bit signed output range.
   function automatic logic [17:0] sat18(input logic signed [21:0] v);
      if (v > 22'sd131071) begin
         return 18'h1FFFF;
      end else if (v < -22'sd131072) begin
         return 18'h20000;
      end else begin
         return v[17:0];
      end
   endfunction

   assign in_ready = (state != S_FIR);
   assign acc      = in_valid & in_ready;

   // Sign-extend the new sample and the taps; products use the pre-shift tap values.
   assign x_e     = 22'($signed(in_tx));
   assign d0_e    = 22'($signed(d0));
   assign d1_e    = 22'($signed(d1));
   assign d2_e    = 22'($signed(d2));
   assign fir_acc = (K_3 * x_e) + (K_1 * d0_e) + (K_1 * d1_e) + (K_3 * d2_e);
   assign ctr_acc = K_CTR * d0_e;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and output-load decode; a pair is always completed before going idle.
   always_comb begin
      state_nxt = state;
      load_fir  = 1'b0;
      load_ctr  = 1'b0;
      vld_nxt   = 1'b0;
      case (state)
         S_IDLE, S_CTR: begin
            if (acc) begin
               load_fir  = 1'b1;
               vld_nxt   = 1'b1;
               state_nxt = S_FIR;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_FIR: begin
            load_ctr  = 1'b1;
            vld_nxt   = 1'b1;
            state_nxt = S_CTR;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Delay line shift and center-phase capture on each accepted sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         d0   <= '0;
         d1   <= '0;
         d2   <= '0;
         hold <= '0;
      end else if (acc) begin
         d0   <= in_tx;
         d1   <= d0;
         d2   <= d1;
         hold <= sat18(ctr_acc);
      end
   end

   // Registered outputs; data and phase hold their last values while out_valid is low.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_tx    <= '0;
         out_phase <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= vld_nxt;
         if (load_fir) begin
            out_tx    <= sat18(fir_acc);
            out_phase <= 1'b0;
         end else if (load_ctr) begin
            out_tx    <= hold;
            out_phase <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hb_interp_tx.sv
// Self-checking bench for hb_interp_tx: vector table, hand-written corner sequences, random stream.
// Expected outputs come from a sample-history model of the interpolator equations.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_hb_interp_tx;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [9:0]  in_tx = '0;
   logic               in_valid = 1'b0;
   logic               in_ready;
   logic signed [17:0] out_tx;
   logic               out_valid;
   logic               out_phase;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int val;
      bit ph;
   } exp_t;

   typedef struct {
      bit rst_before;
      int x;
      int fir;
      int ctr;
   } vec_t;

   exp_t q[$];
   int   h1, h2, h3;
   bit   acc_prev;
   int   obs_tx;
   bit   obs_vld;
   bit   obs_ph;
   vec_t vec[17];

   hb_interp_tx dut (
      .clk       (clk),
      .rst       (rst),
      .in_tx     (in_tx),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_tx    (out_tx),
      .out_valid (out_valid),
      .out_phase (out_phase)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      if (v > 131071) return 131071;
      if (v < -131072) return -131072;
      return v;
   endfunction

   // Model: one accepted sample yields the FIR-phase value then the center-phase value.
   task automatic model_push(input int x);
      exp_t e;
      e.val = sat(-16 * x + 144 * h1 + 144 * h2 - 16 * h3);
      e.ph  = 1'b0;
      q.push_back(e);
      e.val = sat(256 * h1);
      e.ph  = 1'b1;
      q.push_back(e);
      h3 = h2;
      h2 = h1;
      h1 = x;
   endtask

   task automatic model_clear();
      q.delete();
      h1 = 0;
      h2 = 0;
      h3 = 0;
      acc_prev = 1'b0;
   endtask

   // One clock: entered and left at a falling edge.
   task automatic cyc(input bit v, input int x);
      bit   a;
      exp_t e;
      logic [9:0] xs;
      xs       = x[9:0];
      in_valid = v;
      in_tx    = xs;
      chk("in_ready", int'(in_ready), int'(!acc_prev));
      a = v && !acc_prev;
      @(posedge clk);
      if (a) model_push(int'($signed(xs)));
      acc_prev = a;
      @(negedge clk);
      obs_tx  = int'(out_tx);
      obs_vld = out_valid;
      obs_ph  = out_phase;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("mdl_vld", int'(out_valid), 1);
         chk("mdl_tx", obs_tx, e.val);
         chk("mdl_ph", int'(out_phase), int'(e.ph));
      end else begin
         chk("mdl_vld", int'(out_valid), 0);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_clear();
   endtask

   initial begin
      // impulse
      vec[0]  = '{1'b1, 100, -1600, 0};
      vec[1]  = '{1'b0, 0, 14400, 25600};
      vec[2]  = '{1'b0, 0, 14400, 0};
      vec[3]  = '{1'b0, 0, -1600, 0};
      vec[4]  = '{1'b0, 0, 0, 0};
      // DC positive full scale
      vec[5]  = '{1'b1, 511, -8176, 0};
      vec[6]  = '{1'b0, 511, 65408, 130816};
      vec[7]  = '{1'b0, 511, 131071, 130816};
      vec[8]  = '{1'b0, 511, 130816, 130816};
      // DC negative full scale
      vec[9]  = '{1'b1, -512, 8192, 0};
      vec[10] = '{1'b0, -512, -65536, -131072};
      vec[11] = '{1'b0, -512, -131072, -131072};
      vec[12] = '{1'b0, -512, -131072, -131072};
      // saturation
      vec[13] = '{1'b1, -512, 8192, 0};
      vec[14] = '{1'b0, 511, -81904, -131072};
      vec[15] = '{1'b0, 511, -8320, 130816};
      vec[16] = '{1'b0, -512, 131071, 130816};

      model_clear();
      #2;
      chk("rst_out_tx", int'(out_tx), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_phase", int'(out_phase), 0);
      chk("rst_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;

      // Vector table: accept, then hold in_valid high through the busy cycle.
      for (int i = 0; i < 17; i++) begin
         if (vec[i].rst_before) do_reset();
         cyc(1'b1, vec[i].x);
         chk("tbl_fir", obs_tx, vec[i].fir);
         chk("tbl_fir_ph", int'(obs_ph), 0);
         cyc(1'b1, 0);
         chk("tbl_ctr", obs_tx, vec[i].ctr);
         chk("tbl_ctr_ph", int'(obs_ph), 1);
      end

      // Reset asserted during the FIR-phase cycle drops the pair and clears the taps.
      do_reset();
      cyc(1'b1, 300);
      cyc(1'b1, 200);
      chk("pre_rst_vld", int'(obs_vld), 1);
      cyc(1'b1, 300);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", int'(out_tx), 0);
      chk("mid_rst_vld", int'(out_valid), 0);
      chk("mid_rst_ph", int'(out_phase), 0);
      chk("mid_rst_rdy", int'(in_ready), 1);
      @(negedge clk);
      rst = 1'b0;
      model_clear();
      cyc(1'b1, 100);
      chk("post_rst_fir", obs_tx, -1600);
      cyc(1'b1, 0);
      chk("post_rst_ctr", obs_tx, 0);
      cyc(1'b1, 0);
      chk("post_rst_fir2", obs_tx, 14400);
      cyc(1'b1, 0);
      chk("post_rst_ctr2", obs_tx, 25600);

      // Gap of 3 cycles: pair completes, then idle, then resume with latency 1.
      cyc(1'b1, 37);
      chk("gap_fir_vld", int'(obs_vld), 1);
      cyc(1'b0, 0);
      chk("gap_ctr_vld", int'(obs_vld), 1);
      chk("gap_ctr_ph", int'(obs_ph), 1);
      cyc(1'b0, 0);
      chk("gap_idle_vld", int'(obs_vld), 0);
      cyc(1'b0, 0);
      chk("gap_idle_vld2", int'(obs_vld), 0);
      chk("gap_rdy", int'(in_ready), 1);
      cyc(1'b1, -45);
      chk("resume_vld", int'(obs_vld), 1);
      chk("resume_ph", int'(obs_ph), 0);
      cyc(1'b0, 0);

      // Randomized stream against the model.
      for (int n = 0; n < 600; n++) begin
         cyc(($urandom_range(0, 9) < 7), int'($urandom_range(0, 1023)) - 512);
      end
      for (int n = 0; n < 3; n++) cyc(1'b0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
